pc_fetch_sequencer: RTL and testbench
=====================================

# pc_fetch_sequencer

Program-counter sequencer and instruction-fetch controller for the multi-cycle MIPS core. It owns the PC and issues word-aligned fetch requests to instruction memory. It computes redirect targets from the word-offset (`<<2`) forms used by branches and jumps, and holds each fetched instruction until decode accepts it. It sits between instruction memory and the decode stage and consumes redirects from decode.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: first fetch address. Bits [1:0] must be 0.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address. Stable while `imem_req` is high.
- `imem_ack` in 1: fetch complete, `imem_rdata` valid. Ignored when `imem_req` is low.
- `imem_rdata` in 32: fetched word.
- `inst_valid` out 1: held instruction is available to decode.
- `inst` out 32: held instruction word.
- `inst_pc` out 32: address of `inst`.
- `inst_ready` in 1: decode accepts. A transfer occurs when `inst_valid` and `inst_ready` are both high.
- `redirect_valid` in 1: redirect request, one-cycle pulse per redirect.
- `redirect_type` in 2: 00 = branch, 01 = jump, 10 = jump-register, 11 = reserved (ignored).
- `redirect_pc` in 32: PC of the redirecting instruction.
- `redirect_imm` in 32: meaning depends on type.
  - Branch: sign-extended 16-bit offset.
  - Jump: 26-bit target in bits [25:0].
  - Jump-register: absolute address.
- `misalign_err` out 1: one-cycle pulse when a jump-register target has bits [1:0] ≠ 0.

## Operation
- States:
  - FETCH: `imem_req`=1, `imem_addr`=pc.
  - HOLD: `inst_valid`=1.
  - DISCARD: `imem_req`=1, the response is dropped.
- Transitions:
  - FETCH→HOLD on `imem_ack`. `inst` and `inst_pc` are captured and pc becomes pc+4.
  - HOLD→FETCH on transfer.
  - DISCARD→FETCH on `imem_ack`.
- Target arithmetic is 32-bit, modulo 2^32:
  - Branch: `redirect_pc`+4+(`redirect_imm`<<2).
  - Jump: {(`redirect_pc`+4)[31:28], `redirect_imm`[25:0], 2'b00}.
  - Jump-register: `redirect_imm`.
- A misaligned jump-register target:
  - pulses `misalign_err` the following cycle;
  - is not applied;
  - leaves sequencing unchanged.
- Reserved type is ignored entirely.
- Redirect handling (without the delay-slot feature):
  - In HOLD: `inst_valid` is forced low combinationally in the redirect cycle, so no transfer occurs even if `inst_ready` is high. The next state is FETCH with pc = target.
  - In FETCH with no `imem_ack` that cycle: the state moves to DISCARD and pc = target. `imem_req` and `imem_addr` stay unchanged until ack, because requests are never aborted.
  - In FETCH with `imem_ack` in the same cycle: the data is dropped and the next state is FETCH at the target.
  - In DISCARD: the pending target is overwritten, so the latest redirect wins.
- `inst` and `inst_pc` are stable throughout HOLD.

## Timing
- Reset values:
  - `imem_req`=0, `inst_valid`=0, `misalign_err`=0.
  - `inst`=0, `inst_pc`=0, `imem_addr`=`RESET_VECTOR`, state=FETCH.
- Reset takes effect asynchronously mid-operation. An outstanding memory request is abandoned and the memory must tolerate this.
- `imem_req` rises in the first cycle after `rst_n` deasserts.
- `imem_ack` is allowed in the same cycle as request rise (zero-wait memory). `inst_valid` rises the cycle after ack.
- After a transfer in cycle T, `imem_req` is high in T+1 with the next address.
- Minimum rate with zero-wait memory and `inst_ready` tied high: one instruction per 2 cycles.
- A redirect in cycle T produces `imem_addr` = target:
  - at T+1 when no fetch is outstanding;
  - otherwise at ack cycle + 1.

## Configuration
- `PC_BRANCH_DELAY_SLOT_EN` defined: MIPS delay-slot semantics.
  - The first instruction after the redirect is not flushed.
    - If it is held, it remains valid and transfers normally.
    - If it is being fetched, the fetch completes and the instruction is delivered.
  - The fetch that follows the delay-slot transfer uses the target.
  - A redirect arriving while one is already pending overrides the target but does not create a second slot.
- Undefined: immediate-redirect behaviour as described under Operation. No instruction after the redirect reaches decode.

## Test plan
- Reset vector sequencing: reset release with zero-wait ack, `inst_ready`=1, rdata = address.
  - Required: fetch addresses 0x0, 0x4, 0x8.
  - Required: `inst_pc`/`inst` pairs matching, `inst_valid` every second cycle.
- Branch targets: branch redirect with `redirect_pc`=0x100.
  - imm=0xFFFF_FFFF → next fetch at 0x100.
  - imm=3 → next fetch at 0x110.
  - pc=0xFFFF_FFF8, imm=0 → fetch at 0xFFFF_FFFC.
  - pc=0xFFFF_FFFC, imm=0 → fetch at 0x0 (wrap).
- Jump target: `redirect_pc`=0xF000_0010, imm=0x40 → fetch at 0xF000_0100.
- Misaligned jump-register: jump-register with imm=0x1002 → one-cycle `misalign_err`, next fetch is the sequential address.
  - Follow-up jump-register with imm=0x2000 → fetch at 0x2000.
- Redirect during a slow fetch: redirect in cycle 1 of a fetch whose ack arrives 3 cycles later.
  - Required: `imem_addr` held.
  - Required: `inst_valid` stays 0.
  - Required: next request at the target.
- Delay slot on/off: redirect while HOLD with `inst_ready`=1.
  - Without the macro: no transfer occurs.
  - With `PC_BRANCH_DELAY_SLOT_EN`: the held instruction transfers, then the target is fetched.
  - Both builds: `rst_n` pulsed mid-fetch → `imem_req` drops immediately, restart at `RESET_VECTOR`.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// Program-counter sequencer and instruction-fetch controller for the multi-cycle MIPS core.
// Define PC_BRANCH_DELAY_SLOT_EN to build with MIPS branch-delay-slot semantics.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_type,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] redirect_imm,
    output logic        misalign_err
);
    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DISCARD} state_t;

    localparam logic [1:0] RT_BRANCH = 2'b00;
    localparam logic [1:0] RT_JUMP   = 2'b01;
    localparam logic [1:0] RT_JR     = 2'b10;
    localparam logic [1:0] RT_RSVD   = 2'b11;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;   // next address to fetch once the current fetch retires
    logic [31:0] addr_nxt, inst_nxt, inst_pc_nxt;
    logic [31:0] link_pc, target;
    logic        jr_misaligned, take, req_int;
`ifdef PC_BRANCH_DELAY_SLOT_EN
    logic        pend, pend_nxt;
    logic [31:0] pend_tgt, pend_tgt_nxt;
`endif

    always_comb begin
        link_pc       = redirect_pc + 32'd4;
        jr_misaligned = redirect_valid && (redirect_type == RT_JR) && (redirect_imm[1:0] != 2'b00);
        take          = redirect_valid && (redirect_type != RT_RSVD) && !jr_misaligned;
        case (redirect_type)
            RT_BRANCH: target = link_pc + {redirect_imm[29:0], 2'b00};
            RT_JUMP:   target = {link_pc[31:28], redirect_imm[25:0], 2'b00};
            default:   target = redirect_imm;
        endcase
    end

    always_comb begin
        // NOTE: every signal this block drives gets a default first, so no path can infer a latch.
        state_nxt   = state;
        pc_nxt      = pc;
        addr_nxt    = imem_addr;
        inst_nxt    = inst;
        inst_pc_nxt = inst_pc;
        req_int     = 1'b0;
        inst_valid  = 1'b0;
`ifdef PC_BRANCH_DELAY_SLOT_EN
        pend_nxt     = pend;
        pend_tgt_nxt = pend_tgt;
        case (state)
            S_HOLD: begin
                inst_valid = 1'b1;
                if (inst_ready) begin
                    // The word leaving now is the delay slot (or plain sequential code).
                    addr_nxt  = take ? target : (pend ? pend_tgt : pc);
                    pend_nxt  = 1'b0;
                    state_nxt = S_FETCH;
                end else if (take) begin
                    pend_nxt     = 1'b1;
                    pend_tgt_nxt = target;
                end
            end
            default: begin
                req_int = 1'b1;
                if (take) begin
                    pend_nxt     = 1'b1;
                    pend_tgt_nxt = target;
                end
                if (imem_ack) begin
                    inst_nxt    = imem_rdata;
                    inst_pc_nxt = imem_addr;
                    pc_nxt      = imem_addr + 32'd4;
                    state_nxt   = S_HOLD;
                end
            end
        endcase
`else
        case (state)
            S_FETCH: begin
                req_int = 1'b1;
                if (take) begin
                    pc_nxt = target;
                    // A request is never aborted: without ack, ride it out in DISCARD.
                    if (imem_ack) addr_nxt  = target;
                    else          state_nxt = S_DISCARD;
                end else if (imem_ack) begin
                    inst_nxt    = imem_rdata;
                    inst_pc_nxt = imem_addr;
                    pc_nxt      = imem_addr + 32'd4;
                    state_nxt   = S_HOLD;
                end
            end
            S_HOLD: begin
                inst_valid = !take;
                if (take) begin
                    pc_nxt    = target;
                    addr_nxt  = target;
                    state_nxt = S_FETCH;
                end else if (inst_ready) begin
                    addr_nxt  = pc;
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                req_int = 1'b1;
                if (take) pc_nxt = target;
                if (imem_ack) begin
                    addr_nxt  = take ? target : pc;
                    state_nxt = S_FETCH;
                end
            end
        endcase
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_FETCH;
            pc           <= RESET_VECTOR;
            imem_addr    <= RESET_VECTOR;
            inst         <= 32'd0;
            inst_pc      <= 32'd0;
            misalign_err <= 1'b0;
`ifdef PC_BRANCH_DELAY_SLOT_EN
            pend         <= 1'b0;
            pend_tgt     <= 32'd0;
`endif
        end else begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            state        <= state_nxt;
            pc           <= pc_nxt;
            imem_addr    <= addr_nxt;
            inst         <= inst_nxt;
            inst_pc      <= inst_pc_nxt;
            misalign_err <= jr_misaligned;
`ifdef PC_BRANCH_DELAY_SLOT_EN
            pend         <= pend_nxt;
            pend_tgt     <= pend_tgt_nxt;
`endif
        end
    end

    // Reset must drop an outstanding request at once, not at the next edge.
    assign imem_req = req_int & rst_n;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed test-plan cases plus random traffic
// checked against a transaction-level model of the delivered instruction stream.
module tb_pc_fetch_sequencer;
    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk, rst_n;
    logic        imem_req, imem_ack, inst_valid, inst_ready, redirect_valid, misalign_err;
    logic [31:0] imem_addr, imem_rdata, inst, inst_pc, redirect_pc, redirect_imm;
    logic [1:0]  redirect_type;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_xfer = 0;

    // model of the instruction stream decode should see
    logic [31:0] exp_pc, pend_tgt, rdata_xor, hold_addr;
    logic        pend, exp_mis, hold_req;

    pc_fetch_sequencer #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .redirect_valid(redirect_valid), .redirect_type(redirect_type),
        .redirect_pc(redirect_pc), .redirect_imm(redirect_imm), .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_target(input logic [1:0] t, input logic [31:0] rpc,
                                                 input logic [31:0] imm);
        logic [31:0] nxt;
        nxt = rpc + 32'd4;
        case (t)
            2'b00:   return nxt + (imm << 2);
            2'b01:   return {nxt[31:28], imm[25:0], 2'b00};
            default: return imm;
        endcase
    endfunction

    task automatic model_reset();
        exp_pc   = RV;
        pend     = 1'b0;
        pend_tgt = 32'd0;
        exp_mis  = 1'b0;
        hold_req = 1'b0;
    endtask

    // One clock cycle: drive at negedge, sample 1 time unit later, update the model.
    task automatic step(input logic rv, input logic [1:0] rt, input logic [31:0] rpc,
                        input logic [31:0] rimm, input logic rdy, input logic ack_en);
        logic mis, take, xfer;
        logic [31:0] tgt;
        @(negedge clk);
        redirect_valid = rv;
        redirect_type  = rt;
        redirect_pc    = rpc;
        redirect_imm   = rimm;
        inst_ready     = rdy;
        imem_ack       = ack_en & imem_req;
        imem_rdata     = imem_addr ^ rdata_xor;
        #1;
        if (hold_req) begin
            check("req_held", imem_req, 1'b1);
            check("addr_held", imem_addr, hold_addr);
        end
        check("misalign_err", misalign_err, exp_mis);
        mis  = rv && (rt == 2'b10) && (rimm[1:0] != 2'b00);
        take = rv && (rt != 2'b11) && !mis;
        tgt  = model_target(rt, rpc, rimm);
        xfer = inst_valid && inst_ready;
`ifdef PC_BRANCH_DELAY_SLOT_EN
        if (xfer) begin
            check("xfer_pc", inst_pc, exp_pc);
            check("xfer_inst", inst, exp_pc ^ rdata_xor);
            exp_pc = take ? tgt : (pend ? pend_tgt : exp_pc + 32'd4);
            pend   = 1'b0;
            n_xfer++;
        end else if (take) begin
            pend     = 1'b1;
            pend_tgt = tgt;
        end
`else
        if (take) check("no_xfer_on_redirect", xfer, 1'b0);
        if (xfer) begin
            check("xfer_pc", inst_pc, exp_pc);
            check("xfer_inst", inst, exp_pc ^ rdata_xor);
            exp_pc = exp_pc + 32'd4;
            n_xfer++;
        end
        if (take) exp_pc = tgt;
`endif
        exp_mis   = mis;
        hold_req  = imem_req && !imem_ack;
        hold_addr = imem_addr;
    endtask

    task automatic idle(input logic rdy, input logic ack_en);
        step(1'b0, 2'b00, 32'd0, 32'd0, rdy, ack_en);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0; redirect_type = 2'b00; redirect_pc = 32'd0; redirect_imm = 32'd0;
        inst_ready = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
        @(negedge clk); #1;
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", inst_valid, 1'b0);
        check("rst_misalign", misalign_err, 1'b0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_addr", imem_addr, RV);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
    endtask

    // Run fetches until an instruction is held (inst_ready low keeps it there).
    task automatic go_hold();
        for (int i = 0; i < 20; i++) begin
            idle(1'b0, 1'b1);
            if (inst_valid) return;
        end
        check("go_hold_timeout", inst_valid, 1'b1);
    endtask

    task automatic redirect_from_hold(input string tag, input logic [1:0] rt, input logic [31:0] rpc,
                                      input logic [31:0] imm, input logic [31:0] want);
        go_hold();
        step(1'b1, rt, rpc, imm, 1'b1, 1'b0);
`ifdef PC_BRANCH_DELAY_SLOT_EN
        check({tag, "_slot_valid"}, inst_valid, 1'b1);
`else
        check({tag, "_valid_low"}, inst_valid, 1'b0);
`endif
        idle(1'b0, 1'b0);
        check({tag, "_req"}, imem_req, 1'b1);
        check(tag, imem_addr, want);
    endtask

    initial begin
        logic [31:0] a, seq;
        rdata_xor = 32'd0;
        do_reset();

        // reset-vector sequencing, zero-wait memory, rdata = address
        for (int i = 0; i < 6; i++) begin
            idle(1'b1, 1'b1);
            check("seq_valid", inst_valid, 32'(i % 2));
            if (i % 2 == 0) check("seq_addr", imem_addr, RV + 32'(4 * (i / 2)));
        end
        rdata_xor = 32'hC0DE_5A00;

        redirect_from_hold("br_neg1", 2'b00, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0000_0100);
        redirect_from_hold("br_pos3", 2'b00, 32'h0000_0100, 32'h0000_0003, 32'h0000_0110);
        redirect_from_hold("br_top",  2'b00, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFFC);
        redirect_from_hold("br_wrap", 2'b00, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000);
        redirect_from_hold("jump",    2'b01, 32'hF000_0010, 32'h0000_0040, 32'hF000_0100);

        // misaligned jump-register is reported, not applied
        go_hold();
        seq = exp_pc + 32'd4;
        step(1'b1, 2'b10, 32'h0000_0040, 32'h0000_1002, 1'b1, 1'b0);
        check("mis_not_flushed", inst_valid, 1'b1);
        idle(1'b0, 1'b0);
        check("mis_pulse", misalign_err, 1'b1);
        check("mis_seq_addr", imem_addr, seq);
        idle(1'b0, 1'b0);
        check("mis_pulse_end", misalign_err, 1'b0);
        redirect_from_hold("jr_ok", 2'b10, 32'h0000_0040, 32'h0000_2000, 32'h0000_2000);

        // redirect in cycle 1 of a fetch acked three cycles later
        go_hold();
        idle(1'b1, 1'b0);
        a = exp_pc;
        step(1'b1, 2'b00, 32'h0000_0200, 32'h0000_0000, 1'b1, 1'b0);
        check("slow_c1_addr", imem_addr, a);
        for (int i = 0; i < 2; i++) begin
            idle(1'b1, 1'b0);
            check("slow_wait_addr", imem_addr, a);
            check("slow_wait_valid", inst_valid, 1'b0);
        end
        idle(1'b1, 1'b1);
        check("slow_ack_valid", inst_valid, 1'b0);
        idle(1'b1, 1'b0);
`ifdef PC_BRANCH_DELAY_SLOT_EN
        check("slow_slot_valid", inst_valid, 1'b1);
        check("slow_slot_pc", inst_pc, a);
        idle(1'b1, 1'b0);
`else
        check("slow_no_valid", inst_valid, 1'b0);
`endif
        check("slow_tgt_req", imem_req, 1'b1);
        check("slow_tgt_addr", imem_addr, 32'h0000_0204);

        // asynchronous reset in the middle of a fetch
        go_hold();
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);
        check("rst_pre_req", imem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_req_drop", imem_req, 1'b0);
        check("rst_addr_async", imem_addr, RV);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        idle(1'b1, 1'b1);
        check("rst_restart_req", imem_req, 1'b1);
        check("rst_restart_addr", imem_addr, RV);

        // random traffic against the stream model
        n_xfer = 0;
        for (int c = 0; c < 3000; c++) begin
            logic rv;
            logic [1:0] rt;
            logic [31:0] rpc, rimm, r;
            rv  = ($urandom_range(0, 11) == 0);
            rt  = 2'($urandom_range(0, 3));
            rpc = $urandom & 32'hFFFF_FFFC;
            r   = $urandom;
            case (rt)
                2'b00:   rimm = {{16{r[15]}}, r[15:0]};
                2'b10:   rimm = ($urandom_range(0, 3) == 0) ? r : (r & 32'hFFFF_FFFC);
                default: rimm = r;
            endcase
            step(rv, rt, rpc, rimm, ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 0));
        end
        check("random_progress", 32'(n_xfer >= 100), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
